rr_mux4_arbiter: RTL
====================

Name: rr_mux4_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit output channel between four requesters.
- Drives the select of a 4:1 bus mux with the granted index.
- Limits each grant to MAX_HOLD accepted transfers.
- Presents a valid/ready handshake to the downstream consumer.
- Sits between four producer blocks and a single shared sink.

Parameters:
- WIDTH, 8: data width of each requester slice and of out_data.
- MAX_HOLD, 4: maximum accepted transfers per grant before forced rotation; legal range ≥1.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- req, input, 4: request from requester i; held high while it has data.
- in_data, input, 4*WIDTH: requester i data in bits [i*WIDTH +: WIDTH].
- out_ready, input, 1: sink accepts out_data this cycle.
- gnt, output, 4: registered one-hot grant; all-zero when idle.
- sel, output, 2: registered binary index of the current or last grant.
- out_data, output, WIDTH: in_data slice selected by sel; 0 when gnt==0.
- out_valid, output, 1: high when gnt!=0 and req[sel]==1.

Behaviour:
- One clock. Reset is synchronous and active-high. Ports are named clk and rst.
- Reset values: gnt=0, sel=0, out_valid=0, out_data=0, state=IDLE, hold_cnt=0, last=3, so requester 0 has highest priority first.
- A transfer occurs on any edge where out_valid && out_ready.
- FSM has two states: IDLE and BUSY.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, at the edge, grant the round-robin winner. Search order is last+1, last+2, last+3, last (mod 4).
  - Set gnt=onehot(winner), sel=winner, hold_cnt=0, go to BUSY.
  - out_valid rises in the cycle after req first rises (1-cycle grant latency).
- BUSY, release conditions evaluated at each edge:
  - (a) req[sel]==0: release; no transfer counted.
  - (b) transfer && hold_cnt==MAX_HOLD-1: release.
  - (c) transfer otherwise: hold_cnt+1; grant kept.
  - (d) no transfer (out_ready=0): hold everything. The grant is never preempted under backpressure.
- On release:
  - Set last=sel.
  - Re-arbitrate on the same edge using req sampled at that edge. Search order is sel+1..sel, so the current holder is lowest priority.
  - If there is a winner, load the new gnt/sel with hold_cnt=0. No bubble cycle. The same requester may be re-granted if it is the only one requesting.
  - If there is no winner, go to IDLE with gnt=0. sel keeps its value.
- hold_cnt width is clog2(MAX_HOLD)+1. It never exceeds MAX_HOLD-1.
- MAX_HOLD=1 means rotation after every transfer.
- out_data and out_valid are combinational from the registered sel/gnt and the live req/in_data. There is no combinational path from out_ready to out_valid.
- Requester contract:
  - Its in_data slice must be stable while it is granted and out_valid && !out_ready.
  - Dropping req releases the channel at the next edge.
- Reset mid-grant: the next edge forces all reset values, regardless of req/out_ready. Any in-flight transfer is abandoned. Arbitration restarts from requester 0.
- req bits that rise during BUSY are ignored until the next release.

Decomposition:
- Shared header/package holds:
  - FSM state encodings: ST_IDLE=1'b0, ST_BUSY=1'b1.
  - NUM_REQ=4 and SEL_W=2.
  - A rotate-priority function, next_grant(req, last), returning the index and a found flag.
- One sub-module, mux4to1_bus: WIDTH-parameterised 4:1 mux (in, sel → out), instantiated once for the datapath.
- Gating of out_data to 0 is done in rr_mux4_arbiter.

Test Plan:
1. Reset: rst=1 for 2 cycles with req=4'b1111, out_ready=1 → gnt=0, sel=0, out_valid=0 throughout. First edge after rst=0 → gnt=4'b0001, sel=0.
2. Single requester: req=4'b0100, slice2=8'hA5, out_ready=1, MAX_HOLD=4 → gnt=4'b0100, out_data=8'hA5, out_valid=1 every cycle. Re-grant after each 4 transfers with no low out_valid cycle.
3. Full contention: req=4'b1111, out_ready=1 → gnt sequence 0001, 0010, 0100, 1000, 0001, each held exactly 4 cycles (16 transfers per rotation).
4. Backpressure: gnt=4'b0010 after 2 transfers, out_ready=0 for 10 cycles, req=4'b1111 → gnt stays 4'b0010, out_valid=1. After out_ready=1, exactly 2 more transfers, then gnt=4'b0100.
5. Early drop: gnt=4'b0010, req goes 4'b1010→4'b1000 after 1 transfer → next edge gnt=4'b1000, sel=3, no bubble. Later req=0 → IDLE, gnt=0, out_data=0.
6. Mid-op reset: gnt=4'b1000, hold_cnt=2, rst pulsed 1 cycle with req=4'b1001 → gnt=0 after the reset edge. Next edge gnt=4'b0001 (pointer reset, not 1000).

Source files
------------

// File: rtl/rr_mux4_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rr_mux4_arbiter_pkg
//   Shared definitions for the four-way round-robin bus arbiter:
//     NUM_REQ / SEL_W : requester count and width of the binary select
//     state_t         : arbiter FSM encoding (ST_IDLE / ST_BUSY)
//     grant_t         : result of a priority search (found flag + index)
//     next_grant()    : rotating-priority search starting just after 'last'
// ---------------------------------------------------------------------------
package rr_mux4_arbiter_pkg;

   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   typedef struct packed {
      logic             found;
      logic [SEL_W-1:0] idx;
   } grant_t;

   // Search order is last+1, last+2, last+3, last (mod 4). The 2-bit
   // addition wraps naturally, so the previous holder is checked last.
   function automatic grant_t next_grant(input logic [NUM_REQ-1:0] req,
                                         input logic [SEL_W-1:0]   last);
      grant_t           g;
      logic [SEL_W-1:0] cand;
      g.found = 1'b0;
      g.idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = last + SEL_W'(k);
         if (!g.found && req[cand]) begin
            g.found = 1'b1;
            g.idx   = cand;
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/rr_mux4_arbiter_mux4to1_bus.sv
// ---------------------------------------------------------------------------
// mux4to1_bus
//   Plain WIDTH-bit 4:1 bus multiplexer.
//   Ports:
//     in  : four packed slices, slice i in bits [i*WIDTH +: WIDTH]
//     sel : binary slice index
//     out : selected slice
// ---------------------------------------------------------------------------
module mux4to1_bus
   import rr_mux4_arbiter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [NUM_REQ*WIDTH-1:0] in,
   input  logic [SEL_W-1:0]         sel,
   output logic [WIDTH-1:0]         out
);

   always_comb begin
      out = in[0 +: WIDTH];
      case (sel)
         2'd0: out = in[0*WIDTH +: WIDTH];
         2'd1: out = in[1*WIDTH +: WIDTH];
         2'd2: out = in[2*WIDTH +: WIDTH];
         2'd3: out = in[3*WIDTH +: WIDTH];
         default: out = in[0 +: WIDTH];
      endcase
   end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux4_arbiter
//   Round-robin arbiter sharing one WIDTH-bit channel among four requesters.
//   Each grant lasts at most MAX_HOLD accepted transfers, then rotates.
//   Ports:
//     clk, rst   : rising-edge clock, synchronous active-high reset
//     req        : per-requester request, held high while it has data
//     in_data    : requester i data in [i*WIDTH +: WIDTH]
//     out_ready  : sink accepts out_data this cycle
//     gnt        : registered one-hot grant, zero when idle
//     sel        : registered index of the current / last grant
//     out_data   : selected slice, zero when no grant is held
//     out_valid  : grant held and the granted requester still requests
//     dbg_state  : current FSM state
//
//   Handshake: a transfer happens on every rising edge where
//   out_valid && out_ready. out_valid depends only on registered gnt/sel and
//   the live req, never on out_ready, and once a grant is held it is never
//   preempted while the sink stalls.
// ---------------------------------------------------------------------------
module rr_mux4_arbiter
   import rr_mux4_arbiter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] in_data,
   input  logic                     out_ready,
   output logic [NUM_REQ-1:0]       gnt,
   output logic [SEL_W-1:0]         sel,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_valid,
   output state_t                   dbg_state
);

   localparam int                HOLD_W    = $clog2(MAX_HOLD) + 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   state_t               state, state_n;
   logic [NUM_REQ-1:0]   gnt_n;
   logic [SEL_W-1:0]     sel_n;
   logic [SEL_W-1:0]     last, last_n;
   logic [HOLD_W-1:0]    hold_cnt, hold_cnt_n;
   logic                 transfer;
   logic                 release_now;
   logic [SEL_W-1:0]     arb_base;
   grant_t               winner;
   logic [WIDTH-1:0]     mux_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         gnt      <= '0;
         sel      <= '0;
         last     <= SEL_W'(3);
         hold_cnt <= '0;
      end else begin
         state    <= state_n;
         gnt      <= gnt_n;
         sel      <= sel_n;
         last     <= last_n;
         hold_cnt <= hold_cnt_n;
      end
   end

   always_comb begin
      transfer    = out_valid && out_ready;
      // While busy, the holder itself is the rotation base so it ends up
      // lowest priority when the grant is released on this edge.
      arb_base    = (state == ST_BUSY) ? sel : last;
      winner      = next_grant(req, arb_base);
      release_now = (state == ST_BUSY) &&
                    (!req[sel] || (transfer && (hold_cnt == HOLD_LAST)));

      state_n    = state;
      gnt_n      = gnt;
      sel_n      = sel;
      last_n     = last;
      hold_cnt_n = hold_cnt;

      case (state)
         ST_IDLE: begin
            if (winner.found) begin
               state_n    = ST_BUSY;
               gnt_n      = NUM_REQ'(1) << winner.idx;
               sel_n      = winner.idx;
               hold_cnt_n = '0;
            end
         end
         ST_BUSY: begin
            if (release_now) begin
               last_n = sel;
               // Re-grant on the same edge so there is no idle bubble.
               if (winner.found) begin
                  gnt_n      = NUM_REQ'(1) << winner.idx;
                  sel_n      = winner.idx;
                  hold_cnt_n = '0;
               end else begin
                  state_n    = ST_IDLE;
                  gnt_n      = '0;
                  hold_cnt_n = '0;
               end
            end else if (transfer) begin
               hold_cnt_n = hold_cnt + HOLD_W'(1);
            end
         end
         default: begin
            state_n = ST_IDLE;
            gnt_n   = '0;
         end
      endcase
   end

   mux4to1_bus #(
      .WIDTH (WIDTH)
   ) u_mux (
      .in  (in_data),
      .sel (sel),
      .out (mux_out)
   );

   assign out_valid = (|gnt) && req[sel];
   assign out_data  = (|gnt) ? mux_out : '0;
   assign dbg_state = state;

endmodule
